// File: rtl/mem_bus_pkg.sv
// Shared encodings for the byte-wide memory bus: FSM states, bus direction and strobe levels.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2
  } state_t;

  localparam logic DIR_TO_MEM   = 1'b0;
  localparam logic DIR_FROM_MEM = 1'b1;

  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

endpackage

// File: rtl/mem_master.sv
// Byte/word bus initiator: one request in flight, rsp_valid 1+beats*(WAIT_STATES+1) cycles after accept.
// Backpressure: req_ready is high only in IDLE, including the rsp_valid cycle; no queueing.
module mem_master #(
  parameter int WIDTH_ADDR  = 16,
  parameter int WIDTH       = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic [WIDTH_ADDR-1:0] req_addr,
  input  logic [2*WIDTH-1:0]    req_wdata,
  output logic                  rsp_valid,
  output logic [2*WIDTH-1:0]    rsp_rdata,
  output logic                  rsp_err,
  output logic [WIDTH_ADDR-1:0] addr_out,
  output logic                  bus_dir,
  output logic                  load_main_n,
  output logic                  assert_main_n,
  output logic [WIDTH-1:0]      main_out,
  input  logic [WIDTH-1:0]      main_in,
  input  logic                  main_en
);
  import mem_bus_pkg::*;

  localparam logic [3:0] WS_LAST  = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
  localparam state_t     BEAT_ST  = (WAIT_STATES > 0) ? ST_SETUP : ST_STROBE;

  state_t                state;
  state_t                state_nxt;
  logic                  beat;
  logic [3:0]            wait_cnt;
  logic                  r_write;
  logic                  r_wide;
  logic [WIDTH_ADDR-1:0] r_addr;
  logic [2*WIDTH-1:0]    r_wdata;
  logic                  accept;
  logic                  last_beat;

  assign accept    = req_valid && req_ready;
  assign last_beat = !r_wide || beat;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    addr_out      = '0;
    bus_dir       = DIR_FROM_MEM;
    load_main_n   = STROBE_OFF;
    assert_main_n = STROBE_OFF;
    main_out      = '0;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BEAT_ST;
      end
      ST_SETUP: begin
        if (wait_cnt == WS_LAST) state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        state_nxt = last_beat ? ST_IDLE : BEAT_ST;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (state != ST_IDLE) begin
      addr_out = r_addr + WIDTH_ADDR'(beat);
      if (r_write) begin
        bus_dir  = DIR_TO_MEM;
        main_out = beat ? r_wdata[2*WIDTH-1:WIDTH] : r_wdata[WIDTH-1:0];
        // Gate with reset so a strobe cannot land in the cycle the block is being reset.
        if (state == ST_STROBE && !reset) load_main_n = STROBE_ON;
      end else begin
        assert_main_n = STROBE_ON;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat      <= 1'b0;
      wait_cnt  <= '0;
      r_write   <= 1'b0;
      r_wide    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        r_write   <= req_write;
        r_wide    <= req_wide;
        r_addr    <= req_addr;
        r_wdata   <= req_wdata;
        beat      <= 1'b0;
        wait_cnt  <= '0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
      if (state == ST_SETUP) wait_cnt <= wait_cnt + 4'd1;
      if (state == ST_STROBE) begin
        wait_cnt <= '0;
        if (!r_write) begin
          if (beat) rsp_rdata[2*WIDTH-1:WIDTH] <= main_in;
          else      rsp_rdata[WIDTH-1:0]       <= main_in;
          rsp_err <= rsp_err | !main_en;
        end
        if (last_beat) rsp_valid <= 1'b1;
        else           beat      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: WS=0 instance (a) and WS=2 instance (b), each with a byte memory.
module tb_mem_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic        a_valid, a_ready, a_write, a_wide, a_rvld, a_err, a_dir, a_load_n, a_oe_n, a_men;
  logic [15:0] a_addr, a_wdata, a_rdata, a_aout;
  logic [7:0]  a_mout, a_min;
  logic        b_valid, b_ready, b_write, b_wide, b_rvld, b_err, b_dir, b_load_n, b_oe_n, b_men;
  logic [15:0] b_addr, b_wdata, b_rdata, b_aout;
  logic [7:0]  b_mout, b_min;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];
  logic        bd_we_a = 1'b0, bd_we_b = 1'b0, a_inject = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_dat = '0;

  mem_master #(.WIDTH_ADDR(16), .WIDTH(8), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_wide(a_wide), .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rvld),
    .rsp_rdata(a_rdata), .rsp_err(a_err), .addr_out(a_aout), .bus_dir(a_dir),
    .load_main_n(a_load_n), .assert_main_n(a_oe_n), .main_out(a_mout), .main_in(a_min),
    .main_en(a_men)
  );

  mem_master #(.WIDTH_ADDR(16), .WIDTH(8), .WAIT_STATES(2)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_wide(b_wide), .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rvld),
    .rsp_rdata(b_rdata), .rsp_err(b_err), .addr_out(b_aout), .bus_dir(b_dir),
    .load_main_n(b_load_n), .assert_main_n(b_oe_n), .main_out(b_mout), .main_in(b_min),
    .main_en(b_men)
  );

  always @(posedge clk) begin
    if (bd_we_a) mem_a[bd_addr] <= bd_dat;
    else if (!a_load_n && a_dir == 1'b0) mem_a[a_aout] <= a_mout;
  end
  always @(posedge clk) begin
    if (bd_we_b) mem_b[bd_addr] <= bd_dat;
    else if (!b_load_n && b_dir == 1'b0) mem_b[b_aout] <= b_mout;
  end
  assign a_min = mem_a[a_aout];
  assign b_min = mem_b[b_aout];
  assign a_men = !a_oe_n && !a_inject;
  assign b_men = !b_oe_n;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic sel_b, input logic [15:0] ad, input logic [7:0] d);
    bd_we_a = !sel_b;
    bd_we_b = sel_b;
    bd_addr = ad;
    bd_dat  = d;
    step();
    bd_we_a = 1'b0;
    bd_we_b = 1'b0;
  endtask

  task automatic start_a(input logic w, input logic wide, input logic [15:0] ad, input logic [15:0] d);
    a_valid = 1'b1; a_write = w; a_wide = wide; a_addr = ad; a_wdata = d;
    step();
    a_valid = 1'b0; a_addr = 16'hDEAD; a_wdata = 16'h5555;
  endtask

  task automatic start_b(input logic w, input logic wide, input logic [15:0] ad, input logic [15:0] d);
    b_valid = 1'b1; b_write = w; b_wide = wide; b_addr = ad; b_wdata = d;
    step();
    b_valid = 1'b0; b_addr = 16'hDEAD; b_wdata = 16'h5555;
  endtask

  task automatic test_reset;
    logic [46:0] got_a, got_b;
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    got_a = {a_ready, a_rvld, a_rdata, a_err, a_aout, a_dir, a_load_n, a_oe_n, a_mout};
    got_b = {b_ready, b_rvld, b_rdata, b_err, b_aout, b_dir, b_load_n, b_oe_n, b_mout};
    tests++; if (got_a !== {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'b111, 8'h0}) begin fails++; $display("FAIL reset_a: got %h want %h", got_a, {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'b111, 8'h0}); end
    tests++; if (got_b !== {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'b111, 8'h0}) begin fails++; $display("FAIL reset_b: got %h want %h", got_b, {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'b111, 8'h0}); end
  endtask

  task automatic test_byte_write;
    logic [30:0] got;
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL bw_ready: got %b want 1", a_ready); end
    start_a(1'b1, 1'b0, 16'h1234, 16'h005A);
    got = {a_dir, a_load_n, a_oe_n, a_aout, a_mout, a_ready, a_rvld};
    tests++; if (got !== {3'b001, 16'h1234, 8'h5A, 2'b00}) begin fails++; $display("FAIL bw_strobe: got %h want %h", got, {3'b001, 16'h1234, 8'h5A, 2'b00}); end
    step();
    tests++; if ({a_rvld, a_ready, a_dir, a_load_n} !== 4'b1111) begin fails++; $display("FAIL bw_rsp: got %b want 1111", {a_rvld, a_ready, a_dir, a_load_n}); end
    tests++; if (mem_a[16'h1234] !== 8'h5A) begin fails++; $display("FAIL bw_mem: got %h want 5a", mem_a[16'h1234]); end
    step();
    tests++; if (a_rvld !== 1'b0) begin fails++; $display("FAIL bw_pulse: got %b want 0", a_rvld); end
  endtask

  task automatic test_word_read;
    poke(1'b0, 16'h2000, 8'h34);
    poke(1'b0, 16'h2001, 8'h12);
    start_a(1'b0, 1'b1, 16'h2000, 16'h0);
    tests++; if ({a_oe_n, a_dir, a_load_n, a_rvld, a_aout} !== {4'b0110, 16'h2000}) begin fails++; $display("FAIL wr_beat0: got %h want %h", {a_oe_n, a_dir, a_load_n, a_rvld, a_aout}, {4'b0110, 16'h2000}); end
    step();
    tests++; if ({a_oe_n, a_rvld, a_aout} !== {2'b00, 16'h2001}) begin fails++; $display("FAIL wr_beat1: got %h want %h", {a_oe_n, a_rvld, a_aout}, {2'b00, 16'h2001}); end
    step();
    tests++; if ({a_rvld, a_err, a_rdata} !== {2'b10, 16'h1234}) begin fails++; $display("FAIL wr_rsp: got %h want %h", {a_rvld, a_err, a_rdata}, {2'b10, 16'h1234}); end
    step();
  endtask

  task automatic test_word_write_wrap;
    start_a(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    tests++; if ({a_dir, a_load_n, a_aout, a_mout} !== {2'b00, 16'hFFFF, 8'hEF}) begin fails++; $display("FAIL ww_beat0: got %h want %h", {a_dir, a_load_n, a_aout, a_mout}, {2'b00, 16'hFFFF, 8'hEF}); end
    step();
    tests++; if ({a_dir, a_load_n, a_aout, a_mout} !== {2'b00, 16'h0000, 8'hBE}) begin fails++; $display("FAIL ww_beat1: got %h want %h", {a_dir, a_load_n, a_aout, a_mout}, {2'b00, 16'h0000, 8'hBE}); end
    step();
    tests++; if (a_rvld !== 1'b1) begin fails++; $display("FAIL ww_rsp: got %b want 1", a_rvld); end
    tests++; if ({mem_a[16'hFFFF], mem_a[16'h0000]} !== 16'hEFBE) begin fails++; $display("FAIL ww_mem: got %h want efbe", {mem_a[16'hFFFF], mem_a[16'h0000]}); end
    step();
  endtask

  task automatic test_wait_states;
    int oe_cnt, ld_cnt, wr_cnt, lat, ld_at;
    poke(1'b1, 16'h0010, 8'hC3);
    tests++; if (b_ready !== 1'b1) begin fails++; $display("FAIL ws_ready: got %b want 1", b_ready); end
    start_b(1'b0, 1'b0, 16'h0010, 16'h0);
    oe_cnt = 0; ld_cnt = 0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (!b_oe_n) oe_cnt++;
      if (!b_load_n) ld_cnt++;
      if (b_rvld && lat == 0) lat = i;
      step();
    end
    tests++; if (oe_cnt != 3) begin fails++; $display("FAIL ws_rd_oe: got %0d want 3", oe_cnt); end
    tests++; if (lat != 4) begin fails++; $display("FAIL ws_rd_lat: got %0d want 4", lat); end
    tests++; if ({ld_cnt[3:0], b_rdata, b_err} !== {4'd0, 16'h00C3, 1'b0}) begin fails++; $display("FAIL ws_rd_data: got %h want %h", {ld_cnt[3:0], b_rdata, b_err}, {4'd0, 16'h00C3, 1'b0}); end
    start_b(1'b1, 1'b0, 16'h0020, 16'h0077);
    ld_cnt = 0; wr_cnt = 0; lat = 0; ld_at = 0;
    for (int i = 1; i <= 8; i++) begin
      if (b_dir == 1'b0) wr_cnt++;
      if (!b_load_n) begin ld_cnt++; ld_at = i; end
      if (b_rvld && lat == 0) lat = i;
      step();
    end
    tests++; if ({wr_cnt, ld_cnt, ld_at, lat} != {32'd3, 32'd1, 32'd3, 32'd4}) begin fails++; $display("FAIL ws_wr_timing: got dir0=%0d ld=%0d ld_at=%0d lat=%0d want 3 1 3 4", wr_cnt, ld_cnt, ld_at, lat); end
    tests++; if (mem_b[16'h0020] !== 8'h77) begin fails++; $display("FAIL ws_wr_mem: got %h want 77", mem_b[16'h0020]); end
  endtask

  task automatic test_err;
    poke(1'b0, 16'h3000, 8'h11);
    poke(1'b0, 16'h3001, 8'h22);
    a_inject = 1'b1;
    start_a(1'b0, 1'b1, 16'h3000, 16'h0);
    step();
    a_inject = 1'b0;
    step();
    tests++; if ({a_rvld, a_err, a_rdata} !== {2'b11, 16'h2211}) begin fails++; $display("FAIL err_sticky: got %h want %h", {a_rvld, a_err, a_rdata}, {2'b11, 16'h2211}); end
    step();
    start_a(1'b0, 1'b0, 16'h3001, 16'h0);
    tests++; if ({a_err, a_rdata} !== {1'b0, 16'h0}) begin fails++; $display("FAIL err_clear: got %h want 0", {a_err, a_rdata}); end
    step();
    tests++; if ({a_rvld, a_err, a_rdata} !== {2'b10, 16'h0022}) begin fails++; $display("FAIL err_byte: got %h want %h", {a_rvld, a_err, a_rdata}, {2'b10, 16'h0022}); end
    step();
  endtask

  task automatic test_reset_mid;
    logic [46:0] got;
    int rsp_cnt;
    poke(1'b0, 16'h0100, 8'h00);
    poke(1'b0, 16'h0101, 8'h77);
    start_a(1'b1, 1'b1, 16'h0100, 16'hAABB);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = {a_ready, a_rvld, a_rdata, a_err, a_aout, a_dir, a_load_n, a_oe_n, a_mout};
    tests++; if (got !== {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'b111, 8'h0}) begin fails++; $display("FAIL rst_mid_out: got %h want %h", got, {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 3'b111, 8'h0}); end
    tests++; if ({mem_a[16'h0100], mem_a[16'h0101]} !== 16'hBB77) begin fails++; $display("FAIL rst_mid_mem: got %h want bb77", {mem_a[16'h0100], mem_a[16'h0101]}); end
    rsp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_rvld) rsp_cnt++;
      step();
    end
    tests++; if (rsp_cnt != 0) begin fails++; $display("FAIL rst_mid_rsp: got %0d want 0", rsp_cnt); end
  endtask

  task automatic test_back_to_back;
    start_a(1'b0, 1'b0, 16'h2001, 16'h0);
    step();
    tests++; if ({a_rvld, a_ready, a_rdata} !== {2'b11, 16'h0012}) begin fails++; $display("FAIL b2b_rsp1: got %h want %h", {a_rvld, a_ready, a_rdata}, {2'b11, 16'h0012}); end
    start_a(1'b0, 1'b1, 16'h2000, 16'h0);
    tests++; if ({a_rvld, a_oe_n, a_aout, a_rdata} !== {2'b00, 16'h2000, 16'h0}) begin fails++; $display("FAIL b2b_accept: got %h want %h", {a_rvld, a_oe_n, a_aout, a_rdata}, {2'b00, 16'h2000, 16'h0}); end
    step();
    step();
    tests++; if ({a_rvld, a_rdata} !== {1'b1, 16'h1234}) begin fails++; $display("FAIL b2b_rsp2: got %h want %h", {a_rvld, a_rdata}, {1'b1, 16'h1234}); end
    step();
  endtask

  initial begin
    a_valid = 1'b0; a_write = 1'b0; a_wide = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_wide = 1'b0; b_addr = '0; b_wdata = '0;
    #1;
    test_reset();
    test_byte_write();
    test_word_read();
    test_word_write_wrap();
    test_wait_states();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
